// File: rtl/node_cloud_pkg.sv
// Shared types and helpers for the node-side blocks of the node cloud.
// Holds the uplink arbiter state encoding and the node index width helper.
package node_cloud_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic int node_id_w(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

endpackage

// File: rtl/node_uplink_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// searched in circular order, returned both one-hot and as an index.
module rr_picker
    import node_cloud_pkg::*;
#(
    parameter  int NUM_NODES = 4,
    localparam int NODE_ID_W = node_id_w(NUM_NODES)
) (
    input  logic [NUM_NODES-1:0] req,
    input  logic [NODE_ID_W-1:0] rr_ptr,
    output logic [NUM_NODES-1:0] pick,
    output logic [NODE_ID_W-1:0] pick_idx
);

    logic [NUM_NODES-1:0] rotated;
    logic                 found;
    int                   offset;
    int                   pos;

    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner.
    always_comb begin
        rotated  = (req >> rr_ptr) | (req << (NUM_NODES - int'(rr_ptr)));
        found    = 1'b0;
        offset   = 0;
        pick     = '0;
        pick_idx = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        pos = int'(rr_ptr) + offset;
        if (pos >= NUM_NODES) begin
            pos = pos - NUM_NODES;
        end
        if (found) begin
            pick_idx       = NODE_ID_W'(pos);
            pick[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/node_uplink_arbiter.sv
// Round-robin arbiter sharing the 8-bit server uplink among the node array.
// A grant ends on the node's last beat, the burst cap, or an idle timeout.
module node_uplink_arbiter
    import node_cloud_pkg::*;
#(
    parameter  int NUM_NODES    = 4,
    parameter  int DATA_W       = DEFAULT_DATA_W,
    parameter  int MAX_BURST    = 16,
    parameter  int IDLE_TIMEOUT = 32,
    localparam int NODE_ID_W    = node_id_w(NUM_NODES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_NODES-1:0]        node_valid,
    input  logic [NUM_NODES*DATA_W-1:0] node_data,
    input  logic [NUM_NODES-1:0]        node_last,
    output logic [NUM_NODES-1:0]        node_ready,
    output logic                        srv_valid,
    output logic [DATA_W-1:0]           srv_data,
    output logic                        srv_last,
    output logic [NODE_ID_W-1:0]        srv_src,
    input  logic                        srv_ready,
    output logic                        timeout_err
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t             state_q, state_d;
    logic [NUM_NODES-1:0]   grant_q, grant_d;
    logic [NODE_ID_W-1:0]   src_q, src_d;
    logic [NODE_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [NUM_NODES-1:0]   pick_onehot;
    logic [NODE_ID_W-1:0]   pick_idx;
    logic                   cap_hit;
    logic                   handshake;

    rr_picker #(
        .NUM_NODES (NUM_NODES)
    ) u_rr_picker (
        .req      (node_valid),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick_onehot),
        .pick_idx (pick_idx)
    );

    assign cap_hit     = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign handshake   = srv_valid & srv_ready;
    assign srv_src     = src_q;
    assign timeout_err = timeout_err_q;

    // Forward path is steered by the registered grant and is silent outside XFER.
    always_comb begin
        srv_valid  = 1'b0;
        srv_data   = '0;
        srv_last   = 1'b0;
        node_ready = '0;
        if (state_q == XFER) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (grant_q[i]) begin
                    srv_valid     = node_valid[i];
                    srv_data      = node_data[i*DATA_W +: DATA_W];
                    srv_last      = node_last[i] | cap_hit;
                    node_ready[i] = srv_ready;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        src_d         = src_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|node_valid) begin
                    grant_d    = pick_onehot;
                    src_d      = pick_idx;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (handshake) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A stalled but valid byte is not idle time.
                if (srv_valid) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (handshake && srv_last) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end else if (!srv_valid && (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1))) begin
                    grant_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                if (src_q == NODE_ID_W'(NUM_NODES - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = src_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            src_q         <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            src_q         <= src_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_node_uplink_arbiter.sv
// Directed and randomized bench for node_uplink_arbiter; a packet-level
// reference model predicts grant order, beat contents, burst caps and timeouts.
module tb_node_uplink_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  node_valid;
    logic [N*DW-1:0] node_data;
    logic [N-1:0]  node_last;
    logic [N-1:0]  node_ready;
    logic          srv_valid;
    logic [DW-1:0] srv_data;
    logic          srv_last;
    logic [1:0]    srv_src;
    logic          srv_ready;
    logic          timeout_err;

    always #5 clk = ~clk;

    node_uplink_arbiter #(
        .NUM_NODES    (N),
        .DATA_W       (DW),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .node_valid  (node_valid),
        .node_data   (node_data),
        .node_last   (node_last),
        .node_ready  (node_ready),
        .srv_valid   (srv_valid),
        .srv_data    (srv_data),
        .srv_last    (srv_last),
        .srv_src     (srv_src),
        .srv_ready   (srv_ready),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int cyc;
        int src;
        int data;
        int last;
    } beat_t;

    beat_t      beat_log[$];
    logic [7:0] q_data[N][$];
    bit         q_last[N][$];
    logic [7:0] exp_data[N][$];
    bit         exp_last[N][$];
    bit         acc[N];

    int cmp_cnt;
    int err_cnt;
    int cyc;
    int ready_mode;

    int exp_ptr;
    bit g_active;
    int g_node;
    int g_beats;
    int g_idle;
    int tmo_due;
    int tmo_cyc;
    int tmo_count;

    logic          s_valid;
    logic          s_last;
    logic          s_to;
    logic [DW-1:0] s_data;
    logic [N-1:0]  s_ready;
    logic [1:0]    s_src;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n, input logic [7:0] d, input bit l);
        q_data[n].push_back(d);
        q_last[n].push_back(l);
        exp_data[n].push_back(d);
        exp_last[n].push_back(l);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (q_data[i].size() > 0) begin
                node_valid[i]            = 1'b1;
                node_data[i*DW +: DW]    = q_data[i][0];
                node_last[i]             = q_last[i][0];
            end else begin
                node_valid[i]            = 1'b0;
                node_data[i*DW +: DW]    = '0;
                node_last[i]             = 1'b0;
            end
        end
        case (ready_mode)
            0:       srv_ready = 1'b0;
            1:       srv_ready = 1'b1;
            default: srv_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic model_reset();
        exp_ptr  = 0;
        g_active = 1'b0;
        g_node   = 0;
        g_beats  = 0;
        g_idle   = 0;
        tmo_due  = -1;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (exp_data[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: grant goes to the first node with pending bytes at or
    // after the pointer; a grant lasts until a last flag, MB beats, or TO idle cycles.
    task automatic sample_and_model();
        beat_t b;
        bit    exp_l;
        int    cand;
        s_valid = srv_valid;
        s_last  = srv_last;
        s_to    = timeout_err;
        s_data  = srv_data;
        s_ready = node_ready;
        s_src   = srv_src;
        cyc++;
        if (s_to === 1'b1) begin
            tmo_count++;
            tmo_cyc = cyc;
        end
        checkOutput("timeout_err", 32'(s_to), 32'(cyc == tmo_due));
        if (g_active) begin
            checkOutput("node_ready", 32'(s_ready), srv_ready ? (32'd1 << g_node) : 32'd0);
        end
        for (int i = 0; i < N; i++) acc[i] = node_valid[i] & (s_ready[i] === 1'b1);
        if (s_valid === 1'b1 && srv_ready) begin
            if (!g_active) begin
                cand = -1;
                for (int k = 0; k < N; k++) begin
                    if (cand < 0 && exp_data[(exp_ptr + k) % N].size() > 0) cand = (exp_ptr + k) % N;
                end
                if (cand < 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    g_active = 1'b1;
                    g_node   = cand;
                    g_beats  = 0;
                    g_idle   = 0;
                end
            end
            if (g_active) begin
                if (exp_data[g_node].size() == 0) begin
                    checkOutput("beat_past_end", 32'd1, 32'd0);
                    g_active = 1'b0;
                end else begin
                    exp_l = exp_last[g_node][0] || (g_beats == MB - 1);
                    checkOutput("srv_src", 32'(s_src), 32'(g_node));
                    checkOutput("srv_data", 32'(s_data), 32'(exp_data[g_node][0]));
                    checkOutput("srv_last", 32'(s_last), 32'(exp_l));
                    b.cyc  = cyc;
                    b.src  = g_node;
                    b.data = int'(exp_data[g_node][0]);
                    b.last = int'(exp_l);
                    beat_log.push_back(b);
                    void'(exp_data[g_node].pop_front());
                    void'(exp_last[g_node].pop_front());
                    g_beats++;
                    g_idle = 0;
                    if (exp_l) begin
                        g_active = 1'b0;
                        exp_ptr  = (g_node + 1) % N;
                    end
                end
            end
        end else if (g_active) begin
            if (node_valid[g_node]) begin
                g_idle = 0;
            end else begin
                g_idle++;
                if (g_idle == TO) begin
                    g_active = 1'b0;
                    exp_ptr  = (g_node + 1) % N;
                    tmo_due  = cyc + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_and_model();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && q_data[i].size() > 0) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
        applyStimulus();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (beat_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        checkOutput("wait_log", 32'(beat_log.size() >= n), 32'd1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (!(all_empty() && !g_active) && k < budget) begin
            tick();
            k++;
        end
        checkOutput("drain_done", 32'(all_empty() && !g_active), 32'd1);
        repeat (4) tick();
        checkOutput("quiet_valid", 32'(s_valid), 32'd0);
        checkOutput("quiet_data", 32'(s_data), 32'd0);
        checkOutput("quiet_ready", 32'(s_ready), 32'd0);
    endtask

    function automatic int log_src(input int k);
        return (k < beat_log.size()) ? beat_log[k].src : -1;
    endfunction
    function automatic int log_cyc(input int k);
        return (k < beat_log.size()) ? beat_log[k].cyc : -1000;
    endfunction
    function automatic int log_data(input int k);
        return (k < beat_log.size()) ? beat_log[k].data : -1;
    endfunction
    function automatic int log_last(input int k);
        return (k < beat_log.size()) ? beat_log[k].last : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        node_valid = '0;
        node_data  = '0;
        node_last  = '0;
        srv_ready  = 1'b0;
        ready_mode = 1;
        cmp_cnt    = 0;
        err_cnt    = 0;
        cyc        = 0;
        tmo_count  = 0;
        tmo_cyc    = -1;
        model_reset();
        applyStimulus();

        // Reset state
        repeat (3) tick();
        checkOutput("rst_srv_valid", 32'(s_valid), 32'd0);
        checkOutput("rst_srv_last", 32'(s_last), 32'd0);
        checkOutput("rst_srv_data", 32'(s_data), 32'd0);
        checkOutput("rst_node_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_srv_src", 32'(s_src), 32'd0);
        checkOutput("rst_timeout", 32'(s_to), 32'd0);
        rst = 1'b1;

        // Node 2 sends three bytes back to back
        beat_log.delete();
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        applyStimulus();
        drain(100);
        checkOutput("t1_count", 32'(beat_log.size()), 32'd3);
        checkOutput("t1_src", 32'(log_src(0)), 32'd2);
        checkOutput("t1_b0", 32'(log_data(0)), 32'hA1);
        checkOutput("t1_b2", 32'(log_data(2)), 32'hA3);
        checkOutput("t1_last_mid", 32'(log_last(1)), 32'd0);
        checkOutput("t1_last_end", 32'(log_last(2)), 32'd1);
        checkOutput("t1_gap01", 32'(log_cyc(1) - log_cyc(0)), 32'd1);
        checkOutput("t1_gap12", 32'(log_cyc(2) - log_cyc(1)), 32'd1);

        // Pointer now sits at 3: node 3 beats node 0
        beat_log.delete();
        push(0, 8'h10, 1'b1);
        push(3, 8'h30, 1'b1);
        applyStimulus();
        drain(100);
        checkOutput("t1b_first", 32'(log_src(0)), 32'd3);
        checkOutput("t1b_second", 32'(log_src(1)), 32'd0);

        rst = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b1;

        // Nodes 0 and 3 together from pointer 0
        beat_log.delete();
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b1);
        push(3, 8'h31, 1'b1);
        applyStimulus();
        drain(100);
        checkOutput("t2_first", 32'(log_src(0)), 32'd0);
        checkOutput("t2_third", 32'(log_src(2)), 32'd3);
        checkOutput("t2_switch_gap", 32'(log_cyc(2) - log_cyc(1)), 32'd3);

        // Node 1 streams 20 bytes; burst cap splits it
        beat_log.delete();
        for (int k = 1; k <= 20; k++) push(1, 8'(8'h40 + k), k == 20);
        applyStimulus();
        drain(200);
        checkOutput("t3_count", 32'(beat_log.size()), 32'd20);
        checkOutput("t3_cap_prev", 32'(log_last(14)), 32'd0);
        checkOutput("t3_cap_last", 32'(log_last(15)), 32'd1);
        checkOutput("t3_regrant_src", 32'(log_src(16)), 32'd1);
        checkOutput("t3_regrant_data", 32'(log_data(16)), 32'h51);
        checkOutput("t3_regrant_gap", 32'(log_cyc(16) - log_cyc(15)), 32'd3);

        // Node 0 sends one byte then goes quiet until the timeout
        beat_log.delete();
        tmo_count = 0;
        push(0, 8'h77, 1'b0);
        applyStimulus();
        wait_log(1, 20);
        push(2, 8'h22, 1'b1);
        applyStimulus();
        drain(200);
        checkOutput("t4_tmo_count", 32'(tmo_count), 32'd1);
        checkOutput("t4_tmo_cycle", 32'(tmo_cyc - log_cyc(0)), 32'(TO + 1));
        checkOutput("t4_next_src", 32'(log_src(1)), 32'd2);
        checkOutput("t4_next_gap", 32'(log_cyc(1) - tmo_cyc), 32'd2);

        // Server stalls for 100 cycles under a valid byte
        beat_log.delete();
        tmo_count  = 0;
        ready_mode = 0;
        push(3, 8'h5C, 1'b0);
        push(3, 8'h5D, 1'b1);
        applyStimulus();
        tick();
        for (int k = 0; k < 100; k++) begin
            tick();
            checkOutput("t5_valid", 32'(s_valid), 32'd1);
            checkOutput("t5_data", 32'(s_data), 32'h5C);
            checkOutput("t5_ready", 32'(s_ready), 32'd0);
        end
        ready_mode = 1;
        applyStimulus();
        drain(100);
        checkOutput("t5_tmo_count", 32'(tmo_count), 32'd0);
        checkOutput("t5_count", 32'(beat_log.size()), 32'd2);
        checkOutput("t5_src", 32'(log_src(1)), 32'd3);

        // Reset in the middle of a node 1 burst
        beat_log.delete();
        for (int k = 0; k < 8; k++) push(1, 8'(8'h60 + k), k == 7);
        applyStimulus();
        wait_log(3, 20);
        rst = 1'b0;
        #1;
        checkOutput("t6_srv_valid", 32'(srv_valid), 32'd0);
        checkOutput("t6_srv_last", 32'(srv_last), 32'd0);
        checkOutput("t6_srv_data", 32'(srv_data), 32'd0);
        checkOutput("t6_node_ready", 32'(node_ready), 32'd0);
        checkOutput("t6_srv_src", 32'(srv_src), 32'd0);
        checkOutput("t6_timeout", 32'(timeout_err), 32'd0);
        model_reset();
        push(0, 8'h0A, 1'b1);
        applyStimulus();
        repeat (2) tick();
        rst = 1'b1;
        beat_log.delete();
        drain(200);
        checkOutput("t6_first_src", 32'(log_src(0)), 32'd0);
        checkOutput("t6_first_data", 32'(log_data(0)), 32'h0A);
        checkOutput("t6_resume_src", 32'(log_src(1)), 32'd1);
        checkOutput("t6_resume_data", 32'(log_data(1)), 32'h63);

        // Randomized traffic on all nodes with a jittery server
        beat_log.delete();
        tmo_count  = 0;
        ready_mode = 2;
        for (int n = 0; n < N; n++) begin
            for (int p = 0; p < 3; p++) begin
                len = int'($urandom_range(1, 24));
                for (int b = 0; b < len; b++) push(n, 8'($urandom_range(0, 255)), b == len - 1);
            end
        end
        applyStimulus();
        drain(6000);
        checkOutput("rand_timeouts", 32'(tmo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/node_uplink_arbiter.md
# node_uplink_arbiter

Round-robin arbiter sharing the single 8-bit server uplink among NUM_NODES node instances. Each node presents a valid/last byte stream. The arbiter grants one node at a time and forwards its bytes to the server link with valid/ready flow control. A grant ends on the node's last beat, on a forced burst cap, or on an idle timeout. It sits between the node array and the server-side link interface.

## Interface
- NUM_NODES, 4: number of requesting nodes (2..16).
- DATA_W, 8: byte width of node and server data.
- MAX_BURST, 16: maximum beats per grant (1..255).
- IDLE_TIMEOUT, 32: cycles a granted node may hold valid low before the grant is revoked (1..255).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- node_valid  in  NUM_NODES  per-node byte valid; also acts as the node's request.
- node_data  in  NUM_NODES*DATA_W  per-node byte; node i occupies bits [i*DATA_W +: DATA_W].
- node_last  in  NUM_NODES  per-node last-beat marker.
- node_ready  out  NUM_NODES  per-node accept; only the granted bit can be 1.
- srv_valid  out  1  byte valid toward server.
- srv_data  out  DATA_W  byte toward server.
- srv_last  out  1  last beat of the current grant.
- srv_src  out  clog2(NUM_NODES)  index of the granted node.
- srv_ready  in  1  server accept.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by idle timeout.

## Operation
- State machine: IDLE, XFER, RELEASE.
- IDLE: when any node_valid is 1, pick the first requester at or after rr_ptr, in circular order. Register grant (one-hot) and srv_src, clear beat_cnt and idle_cnt, go to XFER.
- XFER, forward path (combinational from the registered grant):
  - srv_valid = node_valid[g]
  - srv_data = node_data[g]
  - node_ready[g] = srv_ready
- A handshake (srv_valid & srv_ready) increments beat_cnt.
- srv_last = node_last[g] OR (beat_cnt == MAX_BURST-1). The cap forces last even if the node did not assert it.
- Handshake with srv_last = 1 → RELEASE.
- idle_cnt increments each XFER cycle with node_valid[g] = 0. It clears on any cycle with valid = 1.
- idle_cnt reaching IDLE_TIMEOUT-1 with valid still low → pulse timeout_err, go to RELEASE.
- A valid byte stalled by srv_ready = 0 does not count as idle. The server may stall indefinitely.
- RELEASE: grant cleared, all outputs inactive, rr_ptr ← (g+1) mod NUM_NODES, go to IDLE.
- Non-granted nodes always see node_ready = 0, and their valid is ignored.
- srv_valid, srv_last and node_ready are 0 outside XFER. srv_data is 0 outside XFER.
- Counters are sized to hold MAX_BURST and IDLE_TIMEOUT. No wrap can occur before the exit condition fires.

## Timing
- Reset values:
  - state = IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0, idle_cnt = 0
  - srv_src = 0, timeout_err = 0
  - all srv_* outputs and node_ready = 0
- Reset mid-XFER aborts immediately and asynchronously. The partial burst is dropped; the server simply sees srv_valid fall.
- Request-to-grant latency: node_valid sampled high in IDLE at edge N → XFER from edge N+1. The first byte can hand off in cycle N+1.
- Throughput inside a grant: one byte per cycle while valid and ready are both high.
- Grant switch overhead: exactly 2 dead cycles after the last beat (RELEASE, then IDLE arbitration).
- timeout_err is high for exactly the cycle in which the state is RELEASE, when that RELEASE was entered via timeout.
- All requesters active continuously → grants rotate 0,1,2,…,NUM_NODES-1,0.
- Only one requester → it is re-granted every 3 cycles minimum between bursts.

## Structure
- Shared package node_cloud_pkg holds:
  - arb_state_t enum (IDLE, XFER, RELEASE)
  - NODE_ID_W = clog2(NUM_NODES) helper function
  - DATA_W default constant, used across node-side blocks
- Sub-module rr_picker: purely combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot pick and index.
- The arbiter instantiates one rr_picker plus the FSM, counters and the forward mux.

## Test plan
- Reset, then node 2 sends 3 bytes 0xA1,0xA2,0xA3 with last on the third, srv_ready = 1 → srv_src = 2, the three bytes appear on consecutive cycles with srv_last on 0xA3, and rr_ptr = 3 afterwards.
- Nodes 0 and 3 both request at once with rr_ptr = 0 → node 0 is served first, then node 3 starting exactly 2 cycles after node 0's last beat.
- Node 1 streams 20 bytes with no last, MAX_BURST = 16 → srv_last asserts on byte 16, RELEASE follows, node 1 is re-granted and byte 17 follows the 2-cycle gap.
- Node 0 is granted, sends 1 byte, then drops valid, IDLE_TIMEOUT = 32 → timeout_err pulses 1 cycle after 32 idle cycles, and the grant passes to the next requester.
- srv_ready is held low for 100 cycles with node_valid high → no timeout, srv_data is held stable, and node_ready stays 0; the transfer completes normally after ready rises.
- rst driven to 0 mid-burst → all outputs are 0 without waiting for a clock edge; after release the next grant starts from node 0.
